// File: rtl/ctrl_pkg.sv
// Shared definitions for the accumulator CPU sequencer: opcodes, FSM states
// and instruction field positions.
package ctrl_pkg;

    localparam int OPC_MSB = 11;
    localparam int OPC_LSB = 8;
    localparam int OPD_MSB = 7;
    localparam int OPD_LSB = 0;

    localparam logic [3:0] OP_ADI  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ORR  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LSL  = 4'h6;
    localparam logic [3:0] OP_LSR  = 4'h7;
    localparam logic [3:0] OP_LDA  = 4'h8;
    localparam logic [3:0] OP_STA  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_NOP0 = 4'hD;
    localparam logic [3:0] OP_NOP1 = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEM,
        ST_EXEC,
        ST_HALT
    } state_t;

endpackage

// File: rtl/mem_port.sv
// Data-memory handshake: holds request, direction, address and store data
// stable until acknowledged, and captures read data into the MDR.
module mem_port (
    input  logic       clk,
    input  logic       srst,
    input  logic       start,
    input  logic       start_we,
    input  logic [7:0] start_addr,
    input  logic [7:0] start_wdata,
    input  logic       ack,
    input  logic [7:0] rdata,
    output logic       req,
    output logic       we,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    output logic [7:0] mdr,
    output logic       done
);

    logic       req_reg;
    logic       we_reg;
    logic [7:0] addr_reg;
    logic [7:0] wdata_reg;
    logic [7:0] mdr_reg;

    // An ack only counts while a request is outstanding.
    assign done = req_reg & ack;

    always_ff @(posedge clk) begin
        if (srst) begin
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= 8'h00;
            wdata_reg <= 8'h00;
            mdr_reg   <= 8'h00;
        end else if (start) begin
            req_reg   <= 1'b1;
            we_reg    <= start_we;
            addr_reg  <= start_addr;
            wdata_reg <= start_wdata;
        end else if (done) begin
            req_reg <= 1'b0;
            we_reg  <= 1'b0;
            if (!we_reg) begin
                mdr_reg <= rdata;
            end
        end
    end

    assign req   = req_reg;
    assign we    = we_reg;
    assign addr  = addr_reg;
    assign wdata = wdata_reg;
    assign mdr   = mdr_reg;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/MEM/EXEC sequencer owning ACC, PC and Z/C flags.
// Optional macro CTRL_SINGLE_STEP_EN adds step_i to gate each instruction fetch.
module control_unit
    import ctrl_pkg::*;
#(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic        step_i,
`endif
    output logic [7:0]  imem_addr_o,
    input  logic [11:0] imem_data_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ack_i,
    output logic [2:0]  alu_func_o,
    output logic [7:0]  alu_a_imm_o,
    output logic [7:0]  alu_a_mem_o,
    output logic [7:0]  alu_b_o,
    input  logic [7:0]  alu_result_i,
    input  logic        alu_fz_i,
    input  logic        alu_fc_i,
    output logic [7:0]  acc_o,
    output logic [7:0]  pc_o,
    output logic        fz_o,
    output logic        fc_o,
    output logic        halted_o
);

    state_t      state_reg, state_next;
    logic [11:0] ir_reg, ir_next;
    logic [7:0]  pc_reg, pc_next;
    logic [7:0]  acc_reg, acc_next;
    logic        fz_reg, fz_next;
    logic        fc_reg, fc_next;

    logic        mem_start;
    logic        mem_start_we;
    logic        mem_done;
    logic [7:0]  mdr;
    logic        fetch_go;

    logic [3:0]  dec_op;
    logic [7:0]  dec_opd;
    logic [3:0]  ir_op;

    assign dec_op  = imem_data_i[OPC_MSB:OPC_LSB];
    assign dec_opd = imem_data_i[OPD_MSB:OPD_LSB];
    assign ir_op   = ir_reg[OPC_MSB:OPC_LSB];

`ifdef CTRL_SINGLE_STEP_EN
    assign fetch_go = step_i;
`else
    assign fetch_go = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_FETCH;
            ir_reg    <= 12'h000;
            pc_reg    <= PC_RESET;
            acc_reg   <= 8'h00;
            fz_reg    <= 1'b0;
            fc_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            ir_reg    <= ir_next;
            pc_reg    <= pc_next;
            acc_reg   <= acc_next;
            fz_reg    <= fz_next;
            fc_reg    <= fc_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ir_next      = ir_reg;
        pc_next      = pc_reg;
        acc_next     = acc_reg;
        fz_next      = fz_reg;
        fc_next      = fc_reg;
        mem_start    = 1'b0;
        mem_start_we = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                if (fetch_go) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ir_next = imem_data_i;
                pc_next = pc_reg + 8'd1;
                case (dec_op)
                    OP_ADI: state_next = ST_EXEC;
                    OP_ADD, OP_SUB, OP_AND, OP_ORR,
                    OP_XOR, OP_LSL, OP_LSR, OP_LDA: begin
                        state_next = ST_MEM;
                        mem_start  = 1'b1;
                    end
                    OP_STA: begin
                        state_next   = ST_MEM;
                        mem_start    = 1'b1;
                        mem_start_we = 1'b1;
                    end
                    OP_JMP: begin
                        pc_next    = dec_opd;
                        state_next = ST_FETCH;
                    end
                    OP_JZ: begin
                        if (fz_reg) pc_next = dec_opd;
                        state_next = ST_FETCH;
                    end
                    OP_JC: begin
                        if (fc_reg) pc_next = dec_opd;
                        state_next = ST_FETCH;
                    end
                    OP_HLT:  state_next = ST_HALT;
                    default: state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_done) begin
                    state_next = (ir_op == OP_STA) ? ST_FETCH : ST_EXEC;
                end
            end
            ST_EXEC: begin
                // LDA bypasses the ALU and keeps the carry.
                if (ir_op == OP_LDA) begin
                    acc_next = mdr;
                    fz_next  = (mdr == 8'h00);
                end else begin
                    acc_next = alu_result_i;
                    fz_next  = alu_fz_i;
                    fc_next  = alu_fc_i;
                end
                state_next = ST_FETCH;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase
    end

    mem_port u_mem_port (
        .clk         (clk_i),
        .srst        (rst_i),
        .start       (mem_start),
        .start_we    (mem_start_we),
        .start_addr  (dec_opd),
        .start_wdata (acc_reg),
        .ack         (mem_ack_i),
        .rdata       (mem_rdata_i),
        .req         (mem_req_o),
        .we          (mem_we_o),
        .addr        (mem_addr_o),
        .wdata       (mem_wdata_o),
        .mdr         (mdr),
        .done        (mem_done)
    );

    assign imem_addr_o = pc_reg;
    assign alu_func_o  = ir_reg[OPC_LSB+2:OPC_LSB];
    assign alu_a_imm_o = ir_reg[OPD_MSB:OPD_LSB];
    assign alu_a_mem_o = mdr;
    assign alu_b_o     = acc_reg;
    assign acc_o       = acc_reg;
    assign pc_o        = pc_reg;
    assign fz_o        = fz_reg;
    assign fc_o        = fc_reg;
    assign halted_o    = (state_reg == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: table of short programs plus wrap, wait-state
// and reset-during-MEM sequences, with behavioural ALU, imem and dmem models.
module tb_control_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  imem_addr_o;
    logic [11:0] imem_data_i = 12'h000;
    logic        mem_req_o, mem_we_o;
    logic [7:0]  mem_addr_o, mem_wdata_o;
    logic [7:0]  mem_rdata_i = 8'h00;
    logic        mem_ack_i = 1'b0;
    logic [2:0]  alu_func_o;
    logic [7:0]  alu_a_imm_o, alu_a_mem_o, alu_b_o;
    logic [7:0]  alu_result_i;
    logic        alu_fz_i, alu_fc_i;
    logic [7:0]  acc_o, pc_o;
    logic        fz_o, fc_o, halted_o;
`ifdef CTRL_SINGLE_STEP_EN
    logic        step_i = 1'b1;
`endif

    control_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
`ifdef CTRL_SINGLE_STEP_EN
        .step_i       (step_i),
`endif
        .imem_addr_o  (imem_addr_o),
        .imem_data_i  (imem_data_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .alu_func_o   (alu_func_o),
        .alu_a_imm_o  (alu_a_imm_o),
        .alu_a_mem_o  (alu_a_mem_o),
        .alu_b_o      (alu_b_o),
        .alu_result_i (alu_result_i),
        .alu_fz_i     (alu_fz_i),
        .alu_fc_i     (alu_fc_i),
        .acc_o        (acc_o),
        .pc_o         (pc_o),
        .fz_o         (fz_o),
        .fc_o         (fc_o),
        .halted_o     (halted_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference ALU: carry is carry-out, borrow, or the bit shifted out.
    logic [8:0] alu_t;
    always_comb begin
        alu_t = 9'h000;
        case (alu_func_o)
            3'd0: alu_t = {1'b0, alu_b_o} + {1'b0, alu_a_imm_o};
            3'd1: alu_t = {1'b0, alu_b_o} + {1'b0, alu_a_mem_o};
            3'd2: alu_t = {1'b0, alu_b_o} - {1'b0, alu_a_mem_o};
            3'd3: alu_t = {1'b0, alu_b_o & alu_a_mem_o};
            3'd4: alu_t = {1'b0, alu_b_o | alu_a_mem_o};
            3'd5: alu_t = {1'b0, alu_b_o ^ alu_a_mem_o};
            3'd6: alu_t = {alu_b_o, 1'b0};
            default: alu_t = {alu_b_o[0], 1'b0, alu_b_o[7:1]};
        endcase
    end
    assign alu_result_i = alu_t[7:0];
    assign alu_fz_i     = (alu_t[7:0] == 8'h00);
    assign alu_fc_i     = alu_t[8];

    logic [11:0] imem [256];
    logic [7:0]  dmem [256];
    int          wait_n = 0;
    int          wcnt = 0;
    logic        force_ack = 1'b0;

    always @(posedge clk_i) imem_data_i <= imem[imem_addr_o];

    // Data memory responder: acks after wait_n wait cycles.
    always @(posedge clk_i) begin
        #1;
        if (mem_req_o) begin
            mem_ack_i = (wcnt == wait_n);
            wcnt = wcnt + 1;
        end else begin
            mem_ack_i = 1'b0;
            wcnt = 0;
        end
        if (force_ack) mem_ack_i = 1'b1;
        mem_rdata_i = dmem[mem_addr_o];
        if (mem_ack_i && mem_req_o && mem_we_o) dmem[mem_addr_o] = mem_wdata_o;
    end

    typedef struct packed {
        logic [7:0]  i0;
        logic [7:0]  i1;
        logic [11:0] instr;
        logic [7:0]  mval;
        logic [7:0]  acc;
        logic        fz;
        logic        fc;
        logic [7:0]  pc;
        int          cyc;
        int          req;
        logic [7:0]  mem;
    } vec_t;

    vec_t vecs [20];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_prog(input vec_t v);
        for (int a = 0; a < 256; a++) begin
            imem[a] = 12'hF00;
            dmem[a] = 8'h00;
        end
        imem[0] = {4'h0, v.i0};
        imem[1] = {4'h0, v.i1};
        imem[2] = v.instr;
        dmem[v.instr[7:0]] = v.mval;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        check("rst_acc", 32'(acc_o), 32'h0);
        check("rst_pc", 32'(pc_o), 32'h0);
        check("rst_flags", 32'({fz_o, fc_o, halted_o}), 32'h0);
        check("rst_req", 32'({mem_req_o, mem_we_o}), 32'h0);
        check("rst_mdr", 32'(alu_a_mem_o), 32'h0);
        rst_i = 1'b0;
    endtask

    task automatic run_to_halt(output int cyc, output int reqs, output logic [7:0] first_addr,
                               output logic addr_ok, output logic timeout);
        cyc = 0; reqs = 0; first_addr = 8'h00; addr_ok = 1'b1; timeout = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk_i);
            cyc++;
            @(negedge clk_i);
            if (mem_req_o) begin
                if (reqs == 0) first_addr = mem_addr_o;
                else if (mem_addr_o != first_addr) addr_ok = 1'b0;
                reqs++;
            end
            if (halted_o) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int         cyc, reqs;
        logic [7:0] faddr;
        logic       aok, tmo;
        vec_t       v;

        //          i0     i1     instr    mval   acc    fz    fc    pc     cyc req mem
        vecs[0]  = '{8'h10, 8'h00, 12'h0F5, 8'h00, 8'h05, 1'b0, 1'b1, 8'h04, 11, 0, 8'h00};
        vecs[1]  = '{8'h03, 8'h00, 12'h110, 8'h04, 8'h07, 1'b0, 1'b0, 8'h04, 12, 1, 8'h04};
        vecs[2]  = '{8'h03, 8'h00, 12'h210, 8'h03, 8'h00, 1'b1, 1'b0, 8'h04, 12, 1, 8'h03};
        vecs[3]  = '{8'h03, 8'h00, 12'h210, 8'h05, 8'hFE, 1'b0, 1'b1, 8'h04, 12, 1, 8'h05};
        vecs[4]  = '{8'hF0, 8'h00, 12'h310, 8'h3C, 8'h30, 1'b0, 1'b0, 8'h04, 12, 1, 8'h3C};
        vecs[5]  = '{8'h0F, 8'h00, 12'h410, 8'hF0, 8'hFF, 1'b0, 1'b0, 8'h04, 12, 1, 8'hF0};
        vecs[6]  = '{8'hAA, 8'h00, 12'h510, 8'hAA, 8'h00, 1'b1, 1'b0, 8'h04, 12, 1, 8'hAA};
        vecs[7]  = '{8'h81, 8'h00, 12'h610, 8'h00, 8'h02, 1'b0, 1'b1, 8'h04, 12, 1, 8'h00};
        vecs[8]  = '{8'h01, 8'h00, 12'h710, 8'h00, 8'h00, 1'b1, 1'b1, 8'h04, 12, 1, 8'h00};
        vecs[9]  = '{8'hFF, 8'h01, 12'h820, 8'h05, 8'h05, 1'b0, 1'b1, 8'h04, 12, 1, 8'h05};
        vecs[10] = '{8'h12, 8'h00, 12'h820, 8'h00, 8'h00, 1'b1, 1'b0, 8'h04, 12, 1, 8'h00};
        vecs[11] = '{8'hAA, 8'h00, 12'h930, 8'h00, 8'hAA, 1'b0, 1'b0, 8'h04, 11, 1, 8'hAA};
        vecs[12] = '{8'hFF, 8'h01, 12'h930, 8'h55, 8'h00, 1'b1, 1'b1, 8'h04, 11, 1, 8'h00};
        vecs[13] = '{8'h05, 8'h00, 12'hA40, 8'h00, 8'h05, 1'b0, 1'b0, 8'h41, 10, 0, 8'h00};
        vecs[14] = '{8'h00, 8'h00, 12'hB40, 8'h00, 8'h00, 1'b1, 1'b0, 8'h41, 10, 0, 8'h00};
        vecs[15] = '{8'h05, 8'h00, 12'hB40, 8'h00, 8'h05, 1'b0, 1'b0, 8'h04, 10, 0, 8'h00};
        vecs[16] = '{8'hFF, 8'h01, 12'hC50, 8'h00, 8'h00, 1'b1, 1'b1, 8'h51, 10, 0, 8'h00};
        vecs[17] = '{8'h05, 8'h00, 12'hC50, 8'h00, 8'h05, 1'b0, 1'b0, 8'h04, 10, 0, 8'h00};
        vecs[18] = '{8'h07, 8'h00, 12'hD00, 8'h00, 8'h07, 1'b0, 1'b0, 8'h04, 10, 0, 8'h00};
        vecs[19] = '{8'h09, 8'h00, 12'hE77, 8'h00, 8'h09, 1'b0, 1'b0, 8'h04, 10, 0, 8'h00};

        for (int i = 0; i < 20; i++) begin
            v = vecs[i];
            wait_n = 0;
            load_prog(v);
            do_reset();
            run_to_halt(cyc, reqs, faddr, aok, tmo);
            check("halt_timeout", 32'(tmo), 32'h0);
            check("acc", 32'(acc_o), 32'(v.acc));
            check("fz", 32'(fz_o), 32'(v.fz));
            check("fc", 32'(fc_o), 32'(v.fc));
            check("pc", 32'(pc_o), 32'(v.pc));
            check("cycles", 32'(cyc), 32'(v.cyc));
            check("req_cycles", 32'(reqs), 32'(v.req));
            check("dmem", 32'(dmem[v.instr[7:0]]), 32'(v.mem));
            // Halted state must ignore stray acks and hold everything.
            force_ack = 1'b1;
            repeat (3) @(negedge clk_i);
            force_ack = 1'b0;
            check("frozen_pc", 32'(pc_o), 32'(v.pc));
            check("frozen_acc", 32'(acc_o), 32'(v.acc));
            check("frozen_req", 32'({mem_req_o, halted_o}), 32'h1);
            $display("[TB] vec %0d instr %03h: acc=%02h fz=%0d fc=%0d pc=%02h cyc=%0d req=%0d",
                     i, v.instr, acc_o, fz_o, fc_o, pc_o, cyc, reqs);
        end

        // LDA with three wait states: req held 4 cycles at a stable address.
        v = '{8'h01, 8'h00, 12'h820, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'h04, 15, 4, 8'h5A};
        wait_n = 3;
        load_prog(v);
        do_reset();
        run_to_halt(cyc, reqs, faddr, aok, tmo);
        check("wait_timeout", 32'(tmo), 32'h0);
        check("wait_acc", 32'(acc_o), 32'h5A);
        check("wait_cycles", 32'(cyc), 32'd15);
        check("wait_req_cycles", 32'(reqs), 32'd4);
        check("wait_addr", 32'(faddr), 32'h20);
        check("wait_addr_stable", 32'(aok), 32'h1);
        $display("[TB] wait-state LDA: acc=%02h cyc=%0d req=%0d addr=%02h", acc_o, cyc, reqs, faddr);
        wait_n = 0;

        // PC wrap: JMP FF, then ADI at FF increments PC to 00.
        for (int a = 0; a < 256; a++) imem[a] = 12'hF00;
        imem[0]   = 12'hAFF;
        imem[255] = 12'h007;
        do_reset();
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("wrap_pc", 32'(pc_o), 32'h00);
        check("wrap_imem_addr", 32'(imem_addr_o), 32'h00);
        check("wrap_acc_before", 32'(acc_o), 32'h00);
        @(posedge clk_i);
        @(negedge clk_i);
        check("wrap_acc_after", 32'(acc_o), 32'h07);
        $display("[TB] pc wrap: pc=%02h acc=%02h", pc_o, acc_o);

        // Reset during a MEM wait, then a late ack that must be ignored.
        for (int a = 0; a < 256; a++) begin
            imem[a] = 12'hF00;
            dmem[a] = 8'h00;
        end
        imem[0] = 12'h011;
        imem[1] = 12'h820;
        dmem[8'h20] = 8'h77;
        wait_n = 1000;
        do_reset();
        tmo = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (mem_req_o) begin
                tmo = 1'b0;
                break;
            end
        end
        check("rstmem_req_seen", 32'(tmo), 32'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        imem[0] = 12'hF00;
        @(posedge clk_i);
        @(negedge clk_i);
        check("rstmem_req_drop", 32'(mem_req_o), 32'h0);
        check("rstmem_pc", 32'(pc_o), 32'h00);
        check("rstmem_acc", 32'(acc_o), 32'h00);
        rst_i = 1'b0;
        force_ack = 1'b1;
        tmo = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (halted_o) begin
                tmo = 1'b0;
                break;
            end
        end
        force_ack = 1'b0;
        check("rstmem_halt_timeout", 32'(tmo), 32'h0);
        check("rstmem_acc_after_ack", 32'(acc_o), 32'h00);
        check("rstmem_mdr_after_ack", 32'(alu_a_mem_o), 32'h00);
        check("rstmem_req_after", 32'(mem_req_o), 32'h0);
        $display("[TB] reset in MEM: acc=%02h mdr=%02h halted=%0d", acc_o, alu_a_mem_o, halted_o);
        wait_n = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the 8-bit accumulator CPU. It fetches 12-bit instructions, decodes them, drives the combinational `alu` (function select, immediate, memory operand, accumulator) and owns the accumulator, PC, Z/C flags and the data-memory request/acknowledge handshake. It sits between instruction memory, data memory and the `alu`, and is the only writer of architectural state.

## Interface
Parameters:
- `PC_RESET`, default 8'h00: PC value loaded on reset.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `imem_addr_o`  out  8  instruction address; equals `pc_o`.
- `imem_data_i`  in  12  instruction; synchronous read, valid the cycle after the address; [11:8] opcode, [7:0] operand.
- `mem_req_o`  out  1  data-memory request.
- `mem_we_o`  out  1  1 = write, 0 = read; meaningful only while `mem_req_o` is high.
- `mem_addr_o`  out  8  data address = IR operand.
- `mem_wdata_o`  out  8  store data = accumulator.
- `mem_rdata_i`  in  8  read data, sampled in the `mem_ack_i` cycle.
- `mem_ack_i`  in  1  completes the transaction in the cycle it is high.
- `alu_func_o`  out  3  = opcode[2:0].
- `alu_a_imm_o`  out  8  = IR operand.
- `alu_a_mem_o`  out  8  = memory data register (MDR).
- `alu_b_o`  out  8  = accumulator.
- `alu_result_i`  in  8, `alu_fz_i`  in  1, `alu_fc_i`  in  1: ALU outputs.
- `acc_o`, `pc_o`  out  8; `fz_o`, `fc_o`, `halted_o`  out  1.

## Operation
- Opcodes: 0 ADI (immediate); 1–7 ADD/SUB/AND/ORR/XOR/LSL/LSR (memory operand at the operand address); 8 LDA; 9 STA; A JMP; B JZ; C JC; D and E NOP; F HLT.
- States: FETCH → DECODE → {MEM, EXEC, FETCH, HALT}; MEM → EXEC (reads) or FETCH (STA); EXEC → FETCH; HALT is absorbing.
- FETCH: presents the PC on `imem_addr_o`.
- DECODE: latches IR from `imem_data_i`.
  - Sets `pc <= pc + 1` (8-bit, wraps FF→00).
  - JMP, and JZ/JC with their flag set: `pc <= operand`. Jump wins over the increment.
  - ADI → EXEC. Opcodes 1–8 → MEM (read). STA → MEM (write). NOP and jumps → FETCH. HLT → HALT.
- MEM: holds `mem_req_o` high with a stable address, WE and wdata until `mem_ack_i`; a read stores `mem_rdata_i` into MDR on the ack edge. Wait states are unbounded; there is no timeout.
- EXEC:
  - ALU ops: `acc <= alu_result_i`, `fz <= alu_fz_i`, `fc <= alu_fc_i`.
  - LDA: `acc <= MDR`, `fz <= (MDR == 0)`, `fc` unchanged.
- Flags change only in EXEC. STA, jumps and NOPs leave them untouched.
- `mem_ack_i` is ignored outside MEM.

## Timing
- Reset values: `acc_o`=0, `pc_o`=`PC_RESET`, `fz_o`=`fc_o`=0, `halted_o`=0, `mem_req_o`=0, `mem_we_o`=0, IR and MDR = 0, state = FETCH.
- Cycles per instruction, zero-wait memory:
  - ADI: 3.
  - ALU-mem and LDA: 4.
  - STA: 3.
  - NOP, JMP/JZ/JC taken or not: 2.
  - Each wait cycle adds 1.
- `mem_req_o` rises on the clock edge entering MEM and falls on the edge after the ack. An ack in the first MEM cycle is legal.
- Reset mid-transaction: `mem_req_o` drops at that edge and an in-flight ack is discarded.
- `halted_o` is high from the edge entering HALT. After that, PC, ACC and flags are frozen and `mem_req_o`=0 until reset.

## Configuration
- `CTRL_SINGLE_STEP_EN`:
  - Defined: adds port `step_i` (in, 1). The FSM stalls in FETCH, with the PC held, until it samples `step_i`=1. One instruction then runs to completion.
  - Undefined: the port does not exist and FETCH always advances.

## Structure
- Package `ctrl_pkg`: 4-bit opcode constants, FSM state enum (FETCH, DECODE, MEM, EXEC, HALT), and the field positions of opcode and operand in the instruction.
- One sub-module: `mem_port`. It owns the req/WE/addr/wdata registers and the MDR capture; the FSM sees only `start`/`done`.
- The `alu` is instantiated at the CPU top, not inside this block.

## Test plan
- Reset, then program `ADI 0x05; HLT` → `acc_o`=0x05 on the third edge after reset release; `halted_o`=1 two cycles later; `fz_o`=0.
- MEM[0x10]=0x03, ACC=0x03, `SUB 0x10` → `acc_o`=0x00, `fz_o`=1; `mem_req_o` high for exactly 1 cycle with zero-wait ack.
- `LDA 0x20` with the ack delayed 3 cycles → req high for 4 cycles with the address stable at 0x20; ACC = MEM[0x20]; instruction takes 7 cycles.
- `STA 0x30` with ACC=0xAA → one request with `mem_we_o`=1, `mem_wdata_o`=0xAA; flags unchanged.
- Branches:
  - `JZ 0x40` with fz=0 → PC+1.
  - With fz=1 → PC=0x40.
  - Instruction at 0xFF with no jump → PC wraps to 0x00.
- Assert `rst_i` during a MEM wait → next cycle `mem_req_o`=0 and state is FETCH; a late ack does not change ACC.
